// File: rtl/spi_host_pkg.sv
// Shared encodings and frame geometry for the SPI host controller.
package spi_host_pkg;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT,
    ST_GAP,
    ST_RECV,
    ST_END
  } state_t;

endpackage

// File: rtl/spi_host_shifter.sv
// TX frame shift register, RX byte shift register and shared down-counting bit counter.
module spi_host_shifter
  import spi_host_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_frame,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  tx_shift,
  input  logic                  rx_shift,
  input  logic                  miso,
  input  logic                  load_cnt,
  input  logic [3:0]            cnt_init,
  output logic                  tx_bit,
  output logic [DATA_BITS-1:0]  rx_data,
  output logic                  bit_last
);

  logic [FRAME_BITS-1:0] tx_reg;
  logic [3:0]            bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_reg  <= '0;
      rx_data <= '0;
      bit_cnt <= '0;
    end else begin
      if (load_frame)
        tx_reg <= frame;
      else if (tx_shift)
        tx_reg <= {tx_reg[FRAME_BITS-2:0], 1'b0};
      if (rx_shift)
        rx_data <= {rx_data[DATA_BITS-2:0], miso};
      // saturates at zero; reloaded on every SHIFT/RECV entry
      if (load_cnt)
        bit_cnt <= cnt_init;
      else if ((tx_shift || rx_shift) && bit_cnt != 4'd0)
        bit_cnt <= bit_cnt - 4'd1;
    end
  end

  assign tx_bit   = tx_reg[FRAME_BITS-1];
  assign bit_last = (bit_cnt == 4'd0);

endmodule

// File: rtl/spi_host_ctrl.sv
// SPI host: accepts one command, sends a 10-bit frame, returns the read byte for op 11.
// Optional SPI_HOST_AUTO_READ_EN: op 11 sends read-address then read-data frames.
//
// state | meaning
// IDLE  | SS_n high, ready for a command
// START | SS_n low, MOSI 0 (slave select-detect)
// SHIFT | 10 frame bits out MSB first
// GAP   | slave RAM turnaround before reply
// RECV  | 8 reply bits sampled from MISO
// END   | SS_n high for IDLE_GAP cycles
module spi_host_ctrl
  import spi_host_pkg::*;
#(
  parameter int READ_GAP = 1,
  parameter int IDLE_GAP = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_payload,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam logic [3:0] TX_INIT = 4'(FRAME_BITS - 1);
  localparam logic [3:0] RX_INIT = 4'(DATA_BITS - 1);
  localparam logic [3:0] RG_INIT = 4'((READ_GAP > 0) ? READ_GAP - 1 : 0);
  localparam logic [3:0] IG_INIT = 4'(IDLE_GAP - 1);

  state_t                state, state_nx;
  logic                  ready_en;
  logic [1:0]            frame_op;
  logic [3:0]            gap_cnt, gap_init;
  logic                  gap_load;
  logic                  auto_pend, auto_set, auto_clr;
  logic                  load_frame, tx_shift, rx_shift, load_cnt, rsp_load;
  logic [3:0]            cnt_init;
  logic [FRAME_BITS-1:0] frame_nx;
  logic                  tx_bit, bit_last;
  logic [DATA_BITS-1:0]  rx_data;
  logic                  accept;

  assign accept = cmd_valid && cmd_ready;

  spi_host_shifter u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_frame (load_frame),
    .frame      (frame_nx),
    .tx_shift   (tx_shift),
    .rx_shift   (rx_shift),
    .miso       (MISO),
    .load_cnt   (load_cnt),
    .cnt_init   (cnt_init),
    .tx_bit     (tx_bit),
    .rx_data    (rx_data),
    .bit_last   (bit_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ready_en  <= 1'b0;
      frame_op  <= 2'b00;
      gap_cnt   <= '0;
      auto_pend <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_nx;
      ready_en  <= 1'b1;
      rsp_valid <= rsp_load;
      if (load_frame)
        frame_op <= frame_nx[FRAME_BITS-1 -: 2];
      if (gap_load)
        gap_cnt <= gap_init;
      else if (gap_cnt != 4'd0)
        gap_cnt <= gap_cnt - 4'd1;
      if (auto_set)
        auto_pend <= 1'b1;
      else if (auto_clr)
        auto_pend <= 1'b0;
      if (rsp_load)
        rsp_data <= {rx_data[DATA_BITS-2:0], MISO};
    end
  end

  always_comb begin
    state_nx   = state;
    load_frame = 1'b0;
    frame_nx   = '0;
    tx_shift   = 1'b0;
    rx_shift   = 1'b0;
    load_cnt   = 1'b0;
    cnt_init   = '0;
    gap_load   = 1'b0;
    gap_init   = '0;
    rsp_load   = 1'b0;
    auto_set   = 1'b0;
    auto_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx   = ST_START;
          load_frame = 1'b1;
          frame_nx   = {cmd_op, cmd_payload};
          if (cmd_op == OP_RD_DATA) begin
`ifdef SPI_HOST_AUTO_READ_EN
            frame_nx = {OP_RD_ADDR, cmd_payload};
            auto_set = 1'b1;
`else
            frame_nx = {OP_RD_DATA, 8'h00};
`endif
          end
        end
      end
      ST_START: begin
        state_nx = ST_SHIFT;
        load_cnt = 1'b1;
        cnt_init = TX_INIT;
      end
      ST_SHIFT: begin
        tx_shift = 1'b1;
        if (bit_last) begin
          if (frame_op == OP_RD_DATA) begin
            if (READ_GAP == 0) begin
              state_nx = ST_RECV;
              load_cnt = 1'b1;
              cnt_init = RX_INIT;
            end else begin
              state_nx = ST_GAP;
              gap_load = 1'b1;
              gap_init = RG_INIT;
            end
          end else begin
            state_nx = ST_END;
            gap_load = 1'b1;
            gap_init = IG_INIT;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == 4'd0) begin
          state_nx = ST_RECV;
          load_cnt = 1'b1;
          cnt_init = RX_INIT;
        end
      end
      ST_RECV: begin
        rx_shift = 1'b1;
        if (bit_last) begin
          rsp_load = 1'b1;
          state_nx = ST_END;
          gap_load = 1'b1;
          gap_init = IG_INIT;
        end
      end
      ST_END: begin
        if (gap_cnt == 4'd0) begin
          if (auto_pend) begin
            state_nx   = ST_START;
            load_frame = 1'b1;
            frame_nx   = {OP_RD_DATA, 8'h00};
            auto_clr   = 1'b1;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign cmd_ready = ready_en && (state == ST_IDLE);
  assign SS_n      = !(state inside {ST_START, ST_SHIFT, ST_GAP, ST_RECV});
  assign busy      = (state inside {ST_START, ST_SHIFT, ST_GAP, ST_RECV}) ||
                     (state == ST_END && auto_pend);
  assign MOSI      = (state == ST_SHIFT) && tx_bit;

endmodule
